// File: rtl/fft16_seq_ctrl_if.sv
// rtl/fft16_seq_ctrl_if.sv - start handshake and RAM/butterfly control bundle of the FFT sequencer
interface fft16_seq_ctrl_if #(
  parameter int STAGES = 4
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic              i_start;
  logic              o_ready;
  logic              o_busy;
  logic              o_rd_en;
  logic [STAGES-1:0] o_rd_addr_a;
  logic [STAGES-1:0] o_rd_addr_b;
  logic [STAGES-2:0] o_tw_idx;
  logic              o_bf_valid;
  logic              o_wr_en;
  logic [STAGES-1:0] o_wr_addr_a;
  logic [STAGES-1:0] o_wr_addr_b;
  logic [SW-1:0]     o_stage;
  logic              o_out_valid;
  logic [STAGES-1:0] fft_out_switcher;
  logic              o_FFT_cycle_done;

  modport master (
    output i_start,
    input  o_ready, o_busy, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx, o_bf_valid,
    input  o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage, o_out_valid, fft_out_switcher,
    input  o_FFT_cycle_done
  );

  modport slave (
    input  i_start,
    output o_ready, o_busy, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx, o_bf_valid,
    output o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage, o_out_valid, fft_out_switcher,
    output o_FFT_cycle_done
  );
endinterface

// File: rtl/fft16_seq_ctrl.sv
// rtl/fft16_seq_ctrl.sv - pass/drain/readout sequencer for an in-place radix-2 DIF FFT
module fft16_seq_ctrl #(
  parameter int STAGES = 4,
  parameter int BF_LAT = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  fft16_seq_ctrl_if.slave bus
);
  localparam int PTS = 1 << STAGES;
  localparam int SW  = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_READOUT, S_DONE} state_t;

  state_t            state, state_n;
  logic [SW-1:0]     stage, stage_n;
  logic [STAGES-1:0] cnt, cnt_n;
  logic [2:0]        dcnt, dcnt_n;

  logic [STAGES-1:0] span, pos, grp, run_a, run_b;
  logic [STAGES-2:0] run_tw;
  logic              run_rd, ro_rd;
  logic              rd_en;
  logic [STAGES-1:0] rd_a, rd_b;
  logic [STAGES-2:0] tw;

  logic              wr_en_p [BF_LAT+1];
  logic [STAGES-1:0] wa_p    [BF_LAT+1];
  logic [STAGES-1:0] wb_p    [BF_LAT+1];
  logic              bf_valid_q, out_valid_q;
  logic [STAGES-1:0] k_q;

  function automatic logic [STAGES-1:0] bitrev(input logic [STAGES-1:0] v);
    logic [STAGES-1:0] r;
    for (int i = 0; i < STAGES; i++) r[i] = v[STAGES-1-i];
    return r;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      stage <= '0;
      cnt   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      stage <= stage_n;
      cnt   <= cnt_n;
      dcnt  <= dcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    stage_n = stage;
    cnt_n   = cnt;
    dcnt_n  = dcnt;
    case (state)
      S_IDLE: begin
        if (bus.i_start) begin
          state_n = S_RUN;
          stage_n = '0;
          cnt_n   = '0;
        end
      end
      S_RUN: begin
        if (cnt == STAGES'(PTS/2 - 1)) begin
          state_n = S_DRAIN;
          dcnt_n  = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt == 3'(BF_LAT)) begin
          cnt_n = '0;
          if (stage == SW'(STAGES - 1)) begin
            state_n = S_READOUT;
          end else begin
            state_n = S_RUN;
            stage_n = stage + 1'b1;
          end
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      S_READOUT: begin
        if (cnt == STAGES'(PTS - 1)) state_n = S_DONE;
        else                         cnt_n   = cnt + 1'b1;
      end
      S_DONE: begin
        state_n = S_IDLE;
        stage_n = '0;
        cnt_n   = '0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Butterfly j of a pass: span halves each pass, groups are 2*span apart.
  always_comb begin
    span   = STAGES'(PTS >> (int'(stage) + 1));
    pos    = cnt & (span - 1'b1);
    grp    = cnt >> (STAGES - 1 - int'(stage));
    run_a  = STAGES'(grp << (STAGES - int'(stage))) | pos;
    run_b  = run_a + span;
    run_tw = (STAGES-1)'(pos << stage);
    run_rd = (state == S_RUN);
    ro_rd  = (state == S_READOUT);
  end

  always_comb begin
    rd_en = 1'b0;
    rd_a  = '0;
    rd_b  = '0;
    tw    = '0;
    if (run_rd) begin
      rd_en = 1'b1;
      rd_a  = run_a;
      rd_b  = run_b;
      tw    = run_tw;
    end else if (ro_rd) begin
      rd_en = 1'b1;
      rd_a  = bitrev(cnt);
    end
  end

  // Write-back trails the read by the RAM latency plus the butterfly latency.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= BF_LAT; i++) begin
        wr_en_p[i] <= 1'b0;
        wa_p[i]    <= '0;
        wb_p[i]    <= '0;
      end
      bf_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      k_q         <= '0;
    end else begin
      wr_en_p[0] <= run_rd;
      wa_p[0]    <= run_rd ? run_a : '0;
      wb_p[0]    <= run_rd ? run_b : '0;
      for (int i = 1; i <= BF_LAT; i++) begin
        wr_en_p[i] <= wr_en_p[i-1];
        wa_p[i]    <= wa_p[i-1];
        wb_p[i]    <= wb_p[i-1];
      end
      bf_valid_q  <= run_rd;
      out_valid_q <= ro_rd;
      k_q         <= ro_rd ? cnt : '0;
    end
  end

  assign bus.o_ready          = (state == S_IDLE);
  assign bus.o_busy           = (state != S_IDLE);
  assign bus.o_rd_en          = rd_en;
  assign bus.o_rd_addr_a      = rd_a;
  assign bus.o_rd_addr_b      = rd_b;
  assign bus.o_tw_idx         = tw;
  assign bus.o_bf_valid       = bf_valid_q;
  assign bus.o_wr_en          = wr_en_p[BF_LAT];
  assign bus.o_wr_addr_a      = wa_p[BF_LAT];
  assign bus.o_wr_addr_b      = wb_p[BF_LAT];
  assign bus.o_stage          = stage;
  assign bus.o_out_valid      = out_valid_q;
  assign bus.fft_out_switcher = k_q;
  assign bus.o_FFT_cycle_done = (state == S_DONE);
endmodule

// File: tb/tb_fft16_seq_ctrl.sv
// tb/tb_fft16_seq_ctrl.sv - scoreboard bench for fft16_seq_ctrl, BF_LAT=2 and BF_LAT=0 instances
module tb_fft16_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft16_seq_ctrl_if #(.STAGES(4)) bus_a ();
  fft16_seq_ctrl_if #(.STAGES(4)) bus_b ();

  fft16_seq_ctrl #(.STAGES(4), .BF_LAT(2)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
  fft16_seq_ctrl #(.STAGES(4), .BF_LAT(0)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

  typedef struct { int cyc; int a; int b; int tw; bit run; } rd_t;
  typedef struct { int cyc; int a; int b; } wr_t;
  typedef struct { int cyc; int k; } out_t;
  typedef struct {
    logic [31:0] ready, busy, rd_en, a, b, tw, bf_valid, wr_en, wa, wb, stage, out_valid, k, done;
  } obs_t;

  rd_t  rd_q[$];
  wr_t  wr_q[$];
  out_t out_q[$];
  int   vectors, miscompares, done_cyc, cur_cyc;
  bit   prev_run;

  function automatic int bitrev4(input int k);
    int r = 0;
    for (int i = 0; i < 4; i++) r |= ((k >> i) & 1) << (3 - i);
    return r;
  endfunction

  function automatic int exp_stage(input int n, input int bflat);
    int len = 8 + bflat + 1;
    if (n >= 1 && n <= 4 * len) return (n - 1) / len;
    if (n > 4 * len && n <= done_cyc) return 3;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    vectors++;
    assert (got === 32'(exp)) else begin
      miscompares++;
      $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cur_cyc, got, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) bus_a.i_start = v;
    else          bus_b.i_start = v;
  endtask

  task automatic sample(input int sel, output obs_t o);
    if (sel == 0) begin
      o.ready = 32'(bus_a.o_ready);       o.busy = 32'(bus_a.o_busy);
      o.rd_en = 32'(bus_a.o_rd_en);       o.a = 32'(bus_a.o_rd_addr_a);
      o.b = 32'(bus_a.o_rd_addr_b);       o.tw = 32'(bus_a.o_tw_idx);
      o.bf_valid = 32'(bus_a.o_bf_valid); o.wr_en = 32'(bus_a.o_wr_en);
      o.wa = 32'(bus_a.o_wr_addr_a);      o.wb = 32'(bus_a.o_wr_addr_b);
      o.stage = 32'(bus_a.o_stage);       o.out_valid = 32'(bus_a.o_out_valid);
      o.k = 32'(bus_a.fft_out_switcher);  o.done = 32'(bus_a.o_FFT_cycle_done);
    end else begin
      o.ready = 32'(bus_b.o_ready);       o.busy = 32'(bus_b.o_busy);
      o.rd_en = 32'(bus_b.o_rd_en);       o.a = 32'(bus_b.o_rd_addr_a);
      o.b = 32'(bus_b.o_rd_addr_b);       o.tw = 32'(bus_b.o_tw_idx);
      o.bf_valid = 32'(bus_b.o_bf_valid); o.wr_en = 32'(bus_b.o_wr_en);
      o.wa = 32'(bus_b.o_wr_addr_a);      o.wb = 32'(bus_b.o_wr_addr_b);
      o.stage = 32'(bus_b.o_stage);       o.out_valid = 32'(bus_b.o_out_valid);
      o.k = 32'(bus_b.fft_out_switcher);  o.done = 32'(bus_b.o_FFT_cycle_done);
    end
  endtask

  task automatic chk_zero(input int sel, input string tag);
    obs_t o;
    sample(sel, o);
    chk({tag, "_ready"}, o.ready, 1);      chk({tag, "_busy"}, o.busy, 0);
    chk({tag, "_rd_en"}, o.rd_en, 0);      chk({tag, "_rd_a"}, o.a, 0);
    chk({tag, "_rd_b"}, o.b, 0);           chk({tag, "_tw"}, o.tw, 0);
    chk({tag, "_bf_valid"}, o.bf_valid, 0); chk({tag, "_wr_en"}, o.wr_en, 0);
    chk({tag, "_wr_a"}, o.wa, 0);          chk({tag, "_wr_b"}, o.wb, 0);
    chk({tag, "_stage"}, o.stage, 0);      chk({tag, "_out_valid"}, o.out_valid, 0);
    chk({tag, "_switcher"}, o.k, 0);       chk({tag, "_done"}, o.done, 0);
  endtask

  // Expected event stream for one transform, stamped with the cycle it must appear in.
  task automatic gen_expected(input int bflat);
    int c = 1;
    rd_q.delete(); wr_q.delete(); out_q.delete();
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 8; j++) begin
        int span = 16 >> (s + 1);
        int pos  = j % span;
        int grp  = j / span;
        int a    = grp * 2 * span + pos;
        rd_q.push_back('{c, a, a + span, pos << s, 1'b1});
        wr_q.push_back('{c + 1 + bflat, a, a + span});
        c++;
      end
      c += bflat + 1;
    end
    for (int k = 0; k < 16; k++) begin
      rd_q.push_back('{c, bitrev4(k), 0, 0, 1'b0});
      out_q.push_back('{c + 1, k});
      c++;
    end
    done_cyc = c;
  endtask

  task automatic check_cycle(input int sel, input int n, input int bflat);
    obs_t o;
    rd_t  r;
    wr_t  w;
    out_t q;
    bit   e;
    sample(sel, o);
    chk("ready", o.ready, (n > done_cyc) ? 1 : 0);
    chk("busy", o.busy, (n <= done_cyc) ? 1 : 0);
    chk("stage", o.stage, exp_stage(n, bflat));
    chk("done", o.done, (n == done_cyc) ? 1 : 0);
    chk("bf_valid", o.bf_valid, prev_run ? 1 : 0);
    e = (rd_q.size() > 0) && (rd_q[0].cyc == n);
    chk("rd_en", o.rd_en, e ? 1 : 0);
    prev_run = 1'b0;
    if (e) begin
      r = rd_q.pop_front();
      chk("rd_addr_a", o.a, r.a);
      chk("rd_addr_b", o.b, r.b);
      chk("tw_idx", o.tw, r.tw);
      prev_run = r.run;
    end
    e = (wr_q.size() > 0) && (wr_q[0].cyc == n);
    chk("wr_en", o.wr_en, e ? 1 : 0);
    if (e) begin
      w = wr_q.pop_front();
      chk("wr_addr_a", o.wa, w.a);
      chk("wr_addr_b", o.wb, w.b);
    end
    e = (out_q.size() > 0) && (out_q[0].cyc == n);
    chk("out_valid", o.out_valid, e ? 1 : 0);
    if (e) begin
      q = out_q.pop_front();
      chk("switcher", o.k, q.k);
    end
  endtask

  task automatic do_run(input int sel, input int bflat, input bit busy_pulses, input int rst_cyc);
    int last;
    gen_expected(bflat);
    prev_run = 1'b0;
    last = done_cyc + 3;
    set_start(sel, 1'b1);
    @(posedge clk);
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      cur_cyc = n;
      check_cycle(sel, n, bflat);
      set_start(sel, (busy_pulses && (n == 5 || n == 50)) ? 1'b1 : 1'b0);
      if (n == rst_cyc) begin
        rst_n = 1'b0;
        break;
      end
    end
    if (rst_cyc > 0) begin
      rd_q.delete(); wr_q.delete(); out_q.delete();
      repeat (2) begin
        @(negedge clk);
        cur_cyc++;
        chk_zero(sel, "midrst");
      end
      rst_n = 1'b1;
      repeat (8) begin
        @(negedge clk);
        cur_cyc++;
        chk_zero(sel, "postrst");
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    done_cyc    = 0;
    cur_cyc     = 0;
    prev_run    = 1'b0;
    rst_n         = 1'b0;
    bus_a.i_start = 1'b1;
    bus_b.i_start = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk_zero(0, "rst_a");
      chk_zero(1, "rst_b");
    end
    rst_n         = 1'b1;
    bus_a.i_start = 1'b0;
    bus_b.i_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero(0, "idle_a");
    chk_zero(1, "idle_b");

    do_run(0, 2, 1'b1, 0);
    do_run(0, 2, 1'b0, 20);
    do_run(0, 2, 1'b0, 0);
    do_run(1, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fft16_seq_ctrl.md
# fft16_seq_ctrl

Sequencer for a shared radix-2 DIF butterfly and an in-place 16-point complex sample RAM. It sits between the OFDM front end and the FFT datapath.
- On a start request it steps the butterfly through all STAGES passes and generates the RAM read/write addresses and twiddle indices.
- It inserts pipeline drains between passes.
- It then reads out the bit-reversed results in natural bin order with an output index, and pulses cycle-done.

## Interface
Parameters:
- STAGES, 4, number of radix-2 passes; PTS = 2**STAGES points (16)
- BF_LAT, 2, butterfly pipeline latency in cycles (0..7)

Ports:
- i_clk  in  1  clock; everything is updated on the rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_start  in  1  request one FFT; sampled only in IDLE
- o_ready  out  1  high only in IDLE
- o_busy  out  1  high in every state except IDLE
- o_rd_en  out  1  RAM read strobe; the RAM is synchronous with 1-cycle read latency
- o_rd_addr_a, o_rd_addr_b  out  STAGES  butterfly operand addresses
- o_tw_idx  out  STAGES-1  twiddle index k of W_PTS^k
- o_bf_valid  out  1  high one cycle after o_rd_en in a RUN cycle; aligned with the RAM data into the butterfly
- o_wr_en  out  1  RAM write strobe for the butterfly results
- o_wr_addr_a, o_wr_addr_b  out  STAGES  write-back addresses
- o_stage  out  $clog2(STAGES)  current pass index
- o_out_valid  out  1  a readout bin is on the RAM data port
- fft_out_switcher  out  STAGES  natural-order bin index k, aligned with o_out_valid
- o_FFT_cycle_done  out  1  one-cycle pulse at the end of the transform

## Operation
States: IDLE, RUN, DRAIN, READOUT, DONE.

- **IDLE**
  - Entered at reset and after DONE.
  - i_start=1 moves the FSM to RUN with stage=0 and j=0.
- **RUN** (one butterfly per cycle, j = 0..PTS/2-1)
  - o_rd_en=1.
  - span = PTS>>(stage+1); pos = j mod span; grp = j / span.
  - addr_a = grp*2*span + pos; addr_b = addr_a + span; tw_idx = pos<<stage.
  - On j = PTS/2-1 the FSM moves to DRAIN.
- **DRAIN**
  - Lasts exactly BF_LAT+1 cycles; o_rd_en=0.
  - Exit: to RUN with stage+1 and j=0, or to READOUT if stage = STAGES-1.
- **Write-back**
  - o_wr_en and o_wr_addr_a/b are the RUN-cycle o_rd_en and o_rd_addr_a/b delayed by 1+BF_LAT cycles, through a shift pipeline.
  - Write-back is independent of state.
- **READOUT** (16 cycles, k = 0..PTS-1)
  - o_rd_en=1; o_rd_addr_a = bitrev(k); o_rd_addr_b=0; o_tw_idx=0.
  - After k = PTS-1 the FSM moves to DONE.
- **Readout output delay**
  - o_out_valid is the READOUT-cycle o_rd_en delayed by 1 cycle.
  - fft_out_switcher is k delayed by 1 cycle.
- **DONE**
  - Lasts one cycle; o_FFT_cycle_done=1, together with o_out_valid for k=15.
  - Next state is IDLE.
- **i_start outside IDLE**: ignored and not queued.
- **Reset** (i_rst_n=0 at any edge, including mid-run):
  - All outputs go to 0 at that edge, o_ready goes to 1, and the FSM enters IDLE.
  - The write pipeline is flushed, so there are no stray o_wr_en pulses after reset.
  - While i_rst_n=0, i_start is ignored.
- **Address and index widths**: all arithmetic is unsigned and exact within STAGES bits, with no wrap.

## Timing
Cycle 0 is the edge where i_start is sampled in IDLE. Cycle numbers assume STAGES=4 and BF_LAT=2.

- Per-stage cycles:
  - stage0: RUN 1-8, DRAIN 9-11
  - stage1: RUN 12-19, DRAIN 20-22
  - stage2: RUN 23-30, DRAIN 31-33
  - stage3: RUN 34-41, DRAIN 42-44
- READOUT 45-60; o_out_valid 46-61; DONE 61; o_ready=1 from cycle 62.
- General total: the start edge to o_FFT_cycle_done spans STAGES*(PTS/2+BF_LAT+1)+PTS+1 cycles.
- Write timing:
  - A butterfly read at cycle t is written at cycle t+1+BF_LAT.
  - The last write of each stage precedes the first read of the next stage by exactly 1 cycle, so there is no read-after-write hazard.
- o_stage:
  - Holds the pass index during that pass's RUN and DRAIN.
  - Is 0 in IDLE and STAGES-1 during READOUT and DONE.
- A new i_start is accepted no earlier than cycle 62.

## Test plan
- **Reset**: hold i_rst_n=0 for 3 cycles with i_start=1 → o_ready=1, every other output 0, and no state change.
- **Stage 0 and stage 3 addressing**:
  - Stage 0, cycles 1-8: (a,b,tw) = (0,8,0), (1,9,1) … (7,15,7).
  - Stage 3, cycles 34-41: (0,1,0), (2,3,0) … (14,15,0).
  - Stage 1, j=4: (8,12,0).
- **Write-back and drain**: o_wr_en is high exactly in cycles 4-11, 15-22, 26-33 and 37-44; o_wr_addr_a at cycle 4 is 0; o_rd_en is low in cycles 9-11.
- **Readout order**: cycles 46-61 show fft_out_switcher 0..15 against read addresses 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; o_FFT_cycle_done is high only in cycle 61.
- **Start while busy**: pulse i_start at cycles 5 and 50 → the sequence is unchanged, no second transform runs, and o_ready=1 at cycle 62.
- **Mid-run reset and BF_LAT variant**:
  - Drive i_rst_n=0 at cycle 20 → all outputs are 0 from that edge, with no o_wr_en afterwards.
  - A fresh i_start then completes normally.
  - With BF_LAT=0, o_FFT_cycle_done occurs at cycle 53.
